// File: rtl/pwm_compare_deadtime_16bits_pkg.sv
// Shared types and widths for the compare/dead-time PWM leg.
// The width macros are also used as parameter defaults by the top.
`ifndef PWM_COMPARE_DEADTIME_16BITS_PKG_SV
`define PWM_COMPARE_DEADTIME_16BITS_PKG_SV

`define PWMCOUNT_WIDTH 16
`define DEADTIME_WIDTH 10

package pwm_compare_deadtime_16bits_pkg;

    typedef enum logic {OFF = 1'b0, ON = 1'b1} _pwm_onoff;

    typedef enum logic {CARR_0 = 1'b0, CARR_1 = 1'b1} _carr_sel;

    typedef enum logic {ACTIVE_HIGH = 1'b0, ACTIVE_LOW = 1'b1} _out_pol;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        HIGH_ON    = 3'd1,
        DT_TO_LOW  = 3'd2,
        LOW_ON     = 3'd3,
        DT_TO_HIGH = 3'd4
    } _dt_state;

endpackage

`endif

// File: rtl/pwm_compare_deadtime_16bits_deadtime_fsm.sv
// Dead-time sequencer: turns the registered PWM reference into a
// break-before-make high/low state with a programmable both-off gap.
module pwm_compare_deadtime_16bits_deadtime_fsm
    import pwm_compare_deadtime_16bits_pkg::*;
#(
    parameter int DT_W = `DEADTIME_WIDTH
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            raw_q,
    input  logic [DT_W-1:0] dt_sh,
    input  _pwm_onoff       pwm_onoff,
    output _dt_state        state
);

    logic [DT_W-1:0] cnt;
    logic            dt_zero;

    assign dt_zero = (dt_sh == '0);

    // cnt is loaded with dt_sh-1 so the both-off interval lasts exactly dt_sh cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else if (pwm_onoff == OFF) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    cnt <= dt_sh - DT_W'(1);
                    if (dt_zero) state <= raw_q ? HIGH_ON : LOW_ON;
                    else         state <= raw_q ? DT_TO_HIGH : DT_TO_LOW;
                end
                HIGH_ON: begin
                    if (!raw_q) begin
                        cnt   <= dt_sh - DT_W'(1);
                        state <= dt_zero ? LOW_ON : DT_TO_LOW;
                    end
                end
                LOW_ON: begin
                    if (raw_q) begin
                        cnt   <= dt_sh - DT_W'(1);
                        state <= dt_zero ? HIGH_ON : DT_TO_HIGH;
                    end
                end
                DT_TO_LOW: begin
                    // reference reverted before pwm_l ever asserted: resume high side at once
                    if (raw_q)              state <= HIGH_ON;
                    else if (cnt == '0)     state <= LOW_ON;
                    else                    cnt   <= cnt - DT_W'(1);
                end
                DT_TO_HIGH: begin
                    if (!raw_q)             state <= LOW_ON;
                    else if (cnt == '0)     state <= HIGH_ON;
                    else                    cnt   <= cnt - DT_W'(1);
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/pwm_compare_deadtime_16bits.sv
// One PWM switching leg: shadowed compare against the carrier, then a
// complementary gate pair with dead time and selectable output polarity.
module pwm_compare_deadtime_16bits
    import pwm_compare_deadtime_16bits_pkg::*;
#(
    parameter int CNT_W = `PWMCOUNT_WIDTH,
    parameter int DT_W  = `DEADTIME_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] carrier,
    input  logic             maskevent,
    input  _carr_sel         carrsel,
    input  _pwm_onoff        pwm_onoff,
    input  logic [CNT_W-1:0] compare,
    input  logic [DT_W-1:0]  deadtime,
    input  _out_pol          out_pol,
    output logic             pwm_h,
    output logic             pwm_l,
    output _carr_sel         carrsel_out,
    output logic             dt_active
);

    logic [CNT_W-1:0] cmp_sh;
    logic [DT_W-1:0]  dt_sh;
    _out_pol          pol_sh;
    logic             raw_q;
    _dt_state         state;
    logic             inv;

    // Shadows follow the active copies freely while disabled so a restart uses fresh settings
    always_ff @(posedge clk) begin
        if (reset) begin
            cmp_sh      <= '0;
            dt_sh       <= '0;
            pol_sh      <= ACTIVE_HIGH;
            raw_q       <= 1'b0;
            carrsel_out <= CARR_0;
        end else begin
            if (maskevent || pwm_onoff == OFF) begin
                cmp_sh <= compare;
                dt_sh  <= deadtime;
                pol_sh <= out_pol;
            end
            raw_q       <= (carrier < cmp_sh);
            carrsel_out <= carrsel;
        end
    end

    pwm_compare_deadtime_16bits_deadtime_fsm #(.DT_W(DT_W)) u_fsm (
        .clk       (clk),
        .reset     (reset),
        .raw_q     (raw_q),
        .dt_sh     (dt_sh),
        .pwm_onoff (pwm_onoff),
        .state     (state)
    );

    assign inv       = (pol_sh == ACTIVE_LOW);
    assign pwm_h     = (state == HIGH_ON) ^ inv;
    assign pwm_l     = (state == LOW_ON) ^ inv;
    assign dt_active = (state == DT_TO_LOW) || (state == DT_TO_HIGH);

endmodule

// File: tb/tb_pwm_compare_deadtime_16bits.sv
// Bench for one PWM leg: a cycle model pushes expected outputs per edge,
// a monitor pops and compares them, plus directed duty/dead-time checks.
module tb_pwm_compare_deadtime_16bits;
    import pwm_compare_deadtime_16bits_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] carrier;
    logic        maskevent;
    _carr_sel    carrsel;
    _pwm_onoff   pwm_onoff;
    logic [15:0] compare;
    logic [9:0]  deadtime;
    _out_pol     out_pol;
    logic        pwm_h, pwm_l, dt_active;
    _carr_sel    carrsel_out;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pwm_compare_deadtime_16bits #(.CNT_W(16), .DT_W(10)) dut (
        .clk         (clk),
        .reset       (reset),
        .carrier     (carrier),
        .maskevent   (maskevent),
        .carrsel     (carrsel),
        .pwm_onoff   (pwm_onoff),
        .compare     (compare),
        .deadtime    (deadtime),
        .out_pol     (out_pol),
        .pwm_h       (pwm_h),
        .pwm_l       (pwm_l),
        .carrsel_out (carrsel_out),
        .dt_active   (dt_active)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: tracks the target side and remaining both-off cycles
    logic [15:0] m_cmp;
    logic [9:0]  m_dt;
    logic        m_pol, m_raw, m_run, m_side, m_sel;
    int          m_wait;
    logic [3:0]  exp_q[$];

    always @(posedge clk) begin
        logic nraw, eh, el, ed;
        if (reset) begin
            m_cmp = '0; m_dt = '0; m_pol = 1'b0; m_raw = 1'b0;
            m_run = 1'b0; m_side = 1'b0; m_wait = 0; m_sel = 1'b0;
        end else begin
            nraw = (carrier < m_cmp);
            if (pwm_onoff == OFF) begin
                m_run = 1'b0; m_wait = 0;
            end else if (!m_run) begin
                m_run = 1'b1; m_side = m_raw; m_wait = int'(m_dt);
            end else if (m_raw != m_side) begin
                m_side = m_raw;
                m_wait = (m_wait > 0) ? 0 : int'(m_dt);
            end else if (m_wait > 0) begin
                m_wait--;
            end
            if (maskevent || pwm_onoff == OFF) begin
                m_cmp = compare; m_dt = deadtime; m_pol = (out_pol == ACTIVE_LOW);
            end
            m_raw = nraw;
            m_sel = (carrsel == CARR_1);
        end
        eh = m_run && m_wait == 0 && m_side;
        el = m_run && m_wait == 0 && !m_side;
        ed = m_run && m_wait > 0;
        exp_q.push_back({eh ^ m_pol, el ^ m_pol, ed, m_sel});
    end

    // Monitor plus per-phase statistics
    int  hcnt = 0, lcnt = 0, dtcnt = 0, ovl = 0;
    int  runlen = 0, dtmin = 1000, dtmax = 0;
    logic runvalid = 1'b0, trk = 1'b0;

    always begin
        logic [3:0] e;
        @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("cycle", {28'd0, pwm_h, pwm_l, dt_active, carrsel_out == CARR_1}, {28'd0, e});
        end
        if (pwm_h === 1'b1) hcnt++;
        if (pwm_l === 1'b1) lcnt++;
        if (dt_active === 1'b1) dtcnt++;
        if (out_pol == ACTIVE_HIGH && pwm_h === 1'b1 && pwm_l === 1'b1) ovl++;
        if (dt_active === 1'b1) begin
            if (runlen == 0) runvalid = trk;
            runlen++;
        end else begin
            if (runlen > 0 && runvalid) begin
                if (runlen < dtmin) dtmin = runlen;
                if (runlen > dtmax) dtmax = runlen;
            end
            runlen = 0;
        end
    end

    int ph = 0;

    task automatic step();
        @(negedge clk);
        carrier   = (ph <= 50) ? 16'(2 * ph) : 16'(2 * (100 - ph));
        maskevent = (ph == 0);
        carrsel   = _carr_sel'($urandom_range(0, 1));
        ph        = (ph + 1) % 100;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic clr();
        hcnt = 0; lcnt = 0; dtcnt = 0;
    endtask

    initial begin
        int dtc;
        logic seen;
        reset = 1'b1; carrier = '0; maskevent = 1'b0; carrsel = CARR_0;
        pwm_onoff = OFF; compare = 16'd40; deadtime = '0; out_pol = ACTIVE_HIGH;
        run(3);
        chk("rst_h", pwm_h, 0);
        chk("rst_l", pwm_l, 0);
        chk("rst_dt", dt_active, 0);
        chk("rst_sel", carrsel_out, CARR_0);
        reset = 1'b0;
        run(1);

        // basic PWM, no dead time
        pwm_onoff = ON;
        run(150); clr(); run(100);
        chk("p1_dtcnt", dtcnt, 0);
        chk("p1_hcnt", hcnt, 39);
        chk("p1_lcnt", lcnt, 61);

        // dead time 5
        deadtime = 10'd5;
        run(200); trk = 1'b1; clr(); run(200); trk = 1'b0;
        chk("p2_dtmin", dtmin, 5);
        chk("p2_dtmax", dtmax, 5);
        chk("p2_hcnt", hcnt, 68);
        chk("p2_lcnt", lcnt, 112);

        // shadow update mid-period
        run(37);
        compare = 16'd70;
        run(200); clr(); run(100);
        chk("p3_hcnt", hcnt, 64);
        chk("p3_lcnt", lcnt, 26);

        // dead-time abort: 3-cycle low excursion against 20-cycle dead time
        pwm_onoff = OFF; compare = 16'd98; deadtime = 10'd20;
        run(2); pwm_onoff = ON;
        run(150); clr(); run(200);
        chk("p4_hcnt", hcnt, 194);
        chk("p4_lcnt", lcnt, 0);

        // boundaries
        pwm_onoff = OFF; compare = 16'd0;
        run(2); pwm_onoff = ON;
        run(50); clr(); run(100);
        chk("p5_cmp0_l", lcnt, 100);
        pwm_onoff = OFF; compare = 16'hFFFF;
        run(2); pwm_onoff = ON;
        run(50); clr(); run(100);
        chk("p5_cmpmax_h", hcnt, 100);
        pwm_onoff = OFF; out_pol = ACTIVE_LOW; compare = 16'd40; deadtime = 10'd5;
        run(2);
        chk("p5_pol_idle_h", pwm_h, 1);
        chk("p5_pol_idle_l", pwm_l, 1);
        pwm_onoff = ON;
        run(200);

        // enable drop mid dead time, then restart
        pwm_onoff = OFF; out_pol = ACTIVE_HIGH; compare = 16'hFFFF; deadtime = 10'd5;
        run(2); pwm_onoff = ON;
        run(2);
        chk("p6_in_dt", dt_active, 1);
        pwm_onoff = OFF;
        run(1);
        chk("p6_off_dt", dt_active, 0);
        chk("p6_off_h", pwm_h, 0);
        chk("p6_off_l", pwm_l, 0);
        pwm_onoff = ON;
        dtc = 0; seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            step();
            if (pwm_h === 1'b1) seen = 1'b1;
            else if (dt_active === 1'b1) dtc++;
        end
        chk("p6_seen_h", seen, 1);
        chk("p6_start_dt", dtc, 5);

        // synchronous reset mid-operation
        compare = 16'd40;
        run(130);
        reset = 1'b1;
        run(1);
        chk("p6_rst_h", pwm_h, 0);
        chk("p6_rst_l", pwm_l, 0);
        chk("p6_rst_dt", dt_active, 0);
        chk("p6_rst_sel", carrsel_out, CARR_0);
        reset = 1'b0;
        run(60);

        chk("overlap", ovl, 0);
        run(2);
        chk("sb_drain", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
